// File: rtl/time_set_ctrl.sv
// time_set_ctrl
//   Keypad-driven controller for the alarm clock's time-keeping datapath.
//   Collects up to four BCD digits, validates them as a 24-hour HH:MM time and
//   issues one-cycle load strobes to the current-time counter or the alarm
//   register. Also selects the display source and abandons idle entries or
//   alarm views after TIMEOUT_SEC one_second ticks without a key.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous, active-low reset
//   one_second      single-cycle tick, once per second
//   key_valid       single-cycle key strobe
//   key[3:0]        0-9 digits, A = ALARM, B = TIME, C-F ignored
//   new_time_*      entered digits (ms_hr, ls_hr, ms_min, ls_min), registered
//   load_new_c      one-cycle strobe: load new_time_* into the time counter
//   load_new_a      one-cycle strobe: load new_time_* into the alarm register
//   show_new_time   display the entered digits
//   show_a          display the alarm time
module time_set_ctrl #(
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key,
    output logic [3:0] new_time_ms_hr,
    output logic [3:0] new_time_ls_hr,
    output logic [3:0] new_time_ms_min,
    output logic [3:0] new_time_ls_min,
    output logic       load_new_c,
    output logic       load_new_a,
    output logic       show_new_time,
    output logic       show_a
);

    localparam logic [3:0] KeyAlarm   = 4'hA;
    localparam logic [3:0] KeyTime    = 4'hB;
    localparam logic [3:0] TimeoutVal = 4'(TIMEOUT_SEC);

    typedef enum logic [2:0] {
        StShowTime  = 3'd0,
        StKeyEntry  = 3'd1,
        StShowAlarm = 3'd2,
        StLoadC     = 3'd3,
        StLoadA     = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] ms_hr_q, ms_hr_d;
    logic [3:0] ls_hr_q, ls_hr_d;
    logic [3:0] ms_min_q, ms_min_d;
    logic [3:0] ls_min_q, ls_min_d;
    logic [2:0] count_q, count_d;
    logic [3:0] tick_q, tick_d;
    logic       load_c_q, load_c_d;
    logic       load_a_q, load_a_d;
    logic       show_new_q, show_new_d;
    logic       show_a_q, show_a_d;

    logic is_digit, is_alarm, is_time, key_acc;
    logic entry_ok, timed, expired;

    always_comb begin
        is_digit = key_valid && (key <= 4'd9);
        is_alarm = key_valid && (key == KeyAlarm);
        is_time  = key_valid && (key == KeyTime);
        key_acc  = key_valid && (key <= KeyTime);

        // Full four-digit entry that forms a legal 24-hour time.
        entry_ok = (count_q == 3'd4) && (ms_hr_q <= 4'd2) && (ms_min_q <= 4'd5) &&
                   ((ms_hr_q != 4'd2) || (ls_hr_q <= 4'd3));

        timed   = (state_q == StKeyEntry) || (state_q == StShowAlarm);
        expired = (tick_q == TimeoutVal);

        state_d  = state_q;
        ms_hr_d  = ms_hr_q;
        ls_hr_d  = ls_hr_q;
        ms_min_d = ms_min_q;
        ls_min_d = ls_min_q;
        count_d  = count_q;

        unique case (state_q)
            StShowTime: begin
                if (is_digit) begin
                    ms_hr_d  = 4'd0;
                    ls_hr_d  = 4'd0;
                    ms_min_d = 4'd0;
                    ls_min_d = key;
                    count_d  = 3'd1;
                    state_d  = StKeyEntry;
                end else if (is_alarm) begin
                    state_d = StShowAlarm;
                end
            end
            StKeyEntry: begin
                if (is_digit) begin
                    ms_hr_d  = ls_hr_q;
                    ls_hr_d  = ms_min_q;
                    ms_min_d = ls_min_q;
                    ls_min_d = key;
                    count_d  = (count_q >= 3'd4) ? 3'd4 : count_q + 3'd1;
                end else if (is_time) begin
                    state_d = entry_ok ? StLoadC : StShowTime;
                end else if (is_alarm) begin
                    state_d = entry_ok ? StLoadA : StShowTime;
                end else if (expired) begin
                    state_d = StShowTime;
                end
            end
            StShowAlarm: begin
                if (is_alarm) begin
                    state_d = StShowTime;
                end else if (!key_acc && expired) begin
                    // Any accepted key, even an ignored digit, keeps the view alive.
                    state_d = StShowTime;
                end
            end
            StLoadC, StLoadA: begin
                state_d = StShowTime;
            end
            default: begin
                state_d = StShowTime;
            end
        endcase

        tick_d = tick_q;
        if ((state_d != state_q) || (timed && key_acc)) begin
            tick_d = 4'd0;
        end else if (timed && one_second) begin
            tick_d = tick_q + 4'd1;
        end

        // Outputs registered from next state so they line up with state_q.
        show_new_d = (state_d == StKeyEntry);
        show_a_d   = (state_d == StShowAlarm);
        load_c_d   = (state_d == StLoadC);
        load_a_d   = (state_d == StLoadA);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StShowTime;
            ms_hr_q    <= 4'd0;
            ls_hr_q    <= 4'd0;
            ms_min_q   <= 4'd0;
            ls_min_q   <= 4'd0;
            count_q    <= 3'd0;
            tick_q     <= 4'd0;
            load_c_q   <= 1'b0;
            load_a_q   <= 1'b0;
            show_new_q <= 1'b0;
            show_a_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ms_hr_q    <= ms_hr_d;
            ls_hr_q    <= ls_hr_d;
            ms_min_q   <= ms_min_d;
            ls_min_q   <= ls_min_d;
            count_q    <= count_d;
            tick_q     <= tick_d;
            load_c_q   <= load_c_d;
            load_a_q   <= load_a_d;
            show_new_q <= show_new_d;
            show_a_q   <= show_a_d;
        end
    end

    assign new_time_ms_hr  = ms_hr_q;
    assign new_time_ls_hr  = ls_hr_q;
    assign new_time_ms_min = ms_min_q;
    assign new_time_ls_min = ls_min_q;
    assign load_new_c      = load_c_q;
    assign load_new_a      = load_a_q;
    assign show_new_time   = show_new_q;
    assign show_a          = show_a_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus randomized key/tick traffic,
// every cycle compared against a behavioural model of the controller.
module tb_time_set_ctrl;

    localparam int TIMEOUT = 10;

    localparam int MShow  = 0;
    localparam int MEntry = 1;
    localparam int MAlarm = 2;
    localparam int MLoadC = 3;
    localparam int MLoadA = 4;

    logic       clk;
    logic       reset;
    logic       one_second;
    logic       key_valid;
    logic [3:0] key;
    logic [3:0] new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min;
    logic       load_new_c, load_new_a, show_new_time, show_a;

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode, digits of the latest entry (oldest first), idle seconds.
    int m_mode;
    int m_q[$];
    int m_idle;

    time_set_ctrl #(.TIMEOUT_SEC(TIMEOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .one_second     (one_second),
        .key_valid      (key_valid),
        .key            (key),
        .new_time_ms_hr (new_time_ms_hr),
        .new_time_ls_hr (new_time_ls_hr),
        .new_time_ms_min(new_time_ms_min),
        .new_time_ls_min(new_time_ls_min),
        .load_new_c     (load_new_c),
        .load_new_a     (load_new_a),
        .show_new_time  (show_new_time),
        .show_a         (show_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dut_digits();
        return int'({new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min});
    endfunction

    function automatic int dut_flags();
        return int'({load_new_c, load_new_a, show_new_time, show_a});
    endfunction

    // Digits shown as a hex number, left-padded with zeros.
    function automatic int model_digits();
        int v = 0;
        foreach (m_q[i]) v = v * 16 + m_q[i];
        return v;
    endfunction

    function automatic int model_flags();
        return ((m_mode == MLoadC) ? 8 : 0) + ((m_mode == MLoadA) ? 4 : 0) +
               ((m_mode == MEntry) ? 2 : 0) + ((m_mode == MAlarm) ? 1 : 0);
    endfunction

    function automatic bit model_entry_ok();
        int hh, mm;
        if (m_q.size() != 4) return 1'b0;
        hh = m_q[0] * 10 + m_q[1];
        mm = m_q[2] * 10 + m_q[3];
        return (hh < 24) && (mm < 60);
    endfunction

    task automatic model_reset();
        m_mode = MShow;
        m_q    = {};
        m_idle = 0;
    endtask

    task automatic model_step(input bit kv, input int k, input bit os);
        int  old   = m_mode;
        bit  acc   = kv && (k <= 11);
        bit  timed = (old == MEntry) || (old == MAlarm);
        bit  gone  = (m_idle == TIMEOUT);
        case (old)
            MShow: begin
                if (kv && k <= 9) begin
                    m_q    = {k};
                    m_mode = MEntry;
                end else if (kv && k == 10) begin
                    m_mode = MAlarm;
                end
            end
            MEntry: begin
                if (kv && k <= 9) begin
                    m_q.push_back(k);
                    if (m_q.size() > 4) void'(m_q.pop_front());
                end else if (kv && k == 11) begin
                    m_mode = model_entry_ok() ? MLoadC : MShow;
                end else if (kv && k == 10) begin
                    m_mode = model_entry_ok() ? MLoadA : MShow;
                end else if (gone) begin
                    m_mode = MShow;
                end
            end
            MAlarm: begin
                if (kv && k == 10) m_mode = MShow;
                else if (!acc && gone) m_mode = MShow;
            end
            default: m_mode = MShow;
        endcase
        if (m_mode != old || (timed && acc)) m_idle = 0;
        else if (timed && os) m_idle++;
    endtask

    task automatic compare_model();
        check_eq("digits", dut_digits(), model_digits());
        check_eq("flags", dut_flags(), model_flags());
    endtask

    task automatic cycle(input bit kv, input int k, input bit os);
        @(negedge clk);
        key_valid  = kv;
        key        = 4'(k);
        one_second = os;
        @(posedge clk);
        model_step(kv, k, os);
        #1;
        compare_model();
    endtask

    task automatic press(input int k);
        cycle(1'b1, k, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b1);
    endtask

    initial begin
        int rate, k;
        reset      = 1'b1;
        one_second = 1'b0;
        key_valid  = 1'b0;
        key        = 4'd0;
        model_reset();
        #2 reset = 1'b0;
        #1;
        check_eq("reset_digits", dut_digits(), 0);
        check_eq("reset_flags", dut_flags(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        idle(2);

        // Normal set 12:34 into the current-time counter.
        press(1); press(2); press(3); press(4);
        check_eq("entry_1234", dut_digits(), 'h1234);
        check_eq("entry_show", show_new_time, 1);
        press(11);
        check_eq("load_c_high", load_new_c, 1);
        check_eq("load_c_digits", dut_digits(), 'h1234);
        idle(1);
        check_eq("load_c_low", load_new_c, 0);
        check_eq("after_load_flags", dut_flags(), 0);

        // Invalid hour rejected, then 23:59 into the alarm.
        press(2); press(4); press(0); press(0); press(10);
        check_eq("reject_2400", dut_flags(), 0);
        press(2); press(3); press(5); press(9); press(10);
        check_eq("load_a_high", load_new_a, 1);
        check_eq("load_a_digits", dut_digits(), 'h2359);
        idle(1);
        check_eq("load_a_low", load_new_a, 0);

        // Oldest digit dropped; short entry rejected.
        press(9); press(1); press(2); press(3); press(0); press(11);
        check_eq("overflow_load", load_new_c, 1);
        check_eq("overflow_digits", dut_digits(), 'h1230);
        press(1); press(2); press(11);
        check_eq("short_reject", dut_flags(), 0);
        idle(1);

        // Timeout in entry.
        press(1); press(2);
        ticks(9);
        check_eq("tick9_show", show_new_time, 1);
        ticks(1);
        idle(1);
        check_eq("tick10_gone", show_new_time, 0);
        press(1); press(2);
        ticks(9);
        cycle(1'b1, 3, 1'b1);
        idle(1);
        check_eq("key_beats_tick", show_new_time, 1);
        check_eq("key_beats_digits", dut_digits(), 'h123);
        press(11);
        idle(1);

        // Alarm view.
        press(10);
        check_eq("alarm_show", show_a, 1);
        press(5);
        check_eq("alarm_digit_ign", show_a, 1);
        check_eq("alarm_digit_keep", dut_digits(), 'h123);
        press(10);
        check_eq("alarm_exit", show_a, 0);
        press(10);
        ticks(9);
        check_eq("alarm_tick9", show_a, 1);
        ticks(1);
        idle(1);
        check_eq("alarm_timeout", show_a, 0);

        // Reset during the load strobe.
        press(1); press(2); press(3); press(4); press(11);
        check_eq("pre_reset_load", load_new_c, 1);
        #1 reset = 1'b0;
        #1;
        model_reset();
        check_eq("async_rst_flags", dut_flags(), 0);
        check_eq("async_rst_digits", dut_digits(), 0);
        @(negedge clk) reset = 1'b1;
        idle(3);
        check_eq("post_rst_load", load_new_c, 0);
        check_eq("post_rst_digits", dut_digits(), 0);

        // Randomized traffic, alternating busy and quiet phases.
        for (int i = 0; i < 4000; i++) begin
            rate = ((i / 200) % 2 == 0) ? 35 : 3;
            if ($urandom_range(0, 9) < 6) k = int'($urandom_range(0, 5));
            else k = int'($urandom_range(0, 15));
            cycle(($urandom_range(0, 99) < rate), k, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
